// File: rtl/pcileech_pcie_tx_arbiter.sv
// Packet-granular arbiter sharing the 64-bit PCIe core TX stream between NUM_REQ TLP sources.
// A grant is held from a packet's first beat to its last; beats reach the core through a one-beat register.
module pcileech_pcie_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int PRIO0      = 1,
    parameter int MIN_BUF_AV = 2
) (
    input  logic                  clk_pcie,
    input  logic                  rst,
    input  logic [NUM_REQ*64-1:0] req_data,
    input  logic [NUM_REQ*8-1:0]  req_keep,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [63:0]           tx_data,
    output logic [7:0]            tx_keep,
    output logic                  tx_last,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [5:0]            tx_buf_av,
    input  logic                  tx_err_drop,
    output logic [2:0]            grant_idx,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_XFER   = 1'b1;
    localparam logic [2:0] GRANT_RST = 3'(NUM_REQ - 1);
    localparam logic [5:0] MIN_AV    = 6'(MIN_BUF_AV);
    localparam logic [3:0] NREQ4     = 4'(NUM_REQ);

    logic [0:0]  state_q, state_d;
    logic [2:0]  grant_idx_q, grant_idx_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic [7:0]  tx_keep_q, tx_keep_d;
    logic        tx_last_q, tx_last_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        out_free;
    logic        in_xfer;
    logic        accept;
    logic [63:0] sel_data;
    logic [7:0]  sel_keep;
    logic        sel_last;
    logic        sel_valid;
    logic [7:0]  vld8;
    logic [3:0]  cand;
    logic        win_found;
    logic [2:0]  win_idx;
    logic        arb_go;

    assign in_xfer  = (state_q == ST_XFER);
    assign out_free = !tx_valid_q || tx_ready;
    assign vld8     = 8'(req_valid);

    // Only the granted requester sees ready; the register refills the same cycle it drains.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = in_xfer && (grant_idx_q == 3'(i)) && out_free;
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == 3'(i)) begin
                sel_data  = req_data[64*i +: 64];
                sel_keep  = req_keep[8*i +: 8];
                sel_last  = req_last[i];
                sel_valid = req_valid[i];
            end
        end
    end

    assign accept = in_xfer && sel_valid && out_free;

    // Round-robin search starts one past the last grant and wraps modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_idx_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, grant_idx_q} + 4'(k);
            if (cand >= NREQ4) begin
                cand = cand - NREQ4;
            end
            if (!win_found && vld8[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
        if ((PRIO0 != 0) && req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = 3'd0;
        end
    end

    assign arb_go = !in_xfer && (|req_valid) && (tx_buf_av >= MIN_AV) && win_found;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_go) begin
                    state_d     = ST_XFER;
                    grant_idx_d = win_idx;
                end
            end
            ST_XFER: begin
                if (accept && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data_d  = tx_data_q;
        tx_keep_d  = tx_keep_q;
        tx_last_d  = tx_last_q;
        tx_valid_d = tx_valid_q;
        if (accept) begin
            tx_data_d  = sel_data;
            tx_keep_d  = sel_keep;
            tx_last_d  = sel_last;
            tx_valid_d = 1'b1;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (tx_err_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= GRANT_RST;
            tx_data_q   <= '0;
            tx_keep_q   <= '0;
            tx_last_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            tx_data_q   <= tx_data_d;
            tx_keep_q   <= tx_keep_d;
            tx_last_q   <= tx_last_d;
            tx_valid_q  <= tx_valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_keep   = tx_keep_q;
    assign tx_last   = tx_last_q;
    assign tx_valid  = tx_valid_q;
    assign grant_idx = grant_idx_q;
    assign busy      = in_xfer;
    assign drop_cnt  = drop_cnt_q;

endmodule
